sa_result_drain: RTL and testbench
==================================

Name: sa_result_drain

Overview:
- Downstream stage of the systolic array. It consumes the full ROWS x COLS accumulator tile in one parallel capture when a matmul completes.
- Each ACC_W accumulator is rescaled by an arithmetic right shift with round-half-up, then saturated to signed DATA_W.
- The tile streams out as ROWS beats of COLS*DATA_W bits on a valid/ready port that drives the core's vec_out data channel.
- A one-cycle done pulse tells the core's FLUSH logic that the tile has fully left.

Parameters:
- ROWS, 8, array rows = number of output beats per tile
- COLS, 8, array columns = lanes per beat
- ACC_W, 32, accumulator width (signed)
- DATA_W, 16, output element width (signed)
- SHIFT_W, 5, width of shift amount (shift range 0..ACC_W-1)

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high
- acc_in  in  ROWS*COLS*ACC_W  tile; element (r,c) at bits [(r*COLS+c)*ACC_W +: ACC_W]
- acc_shift  in  SHIFT_W  right-shift amount, sampled with acc_in
- acc_valid  in  1  tile available
- acc_ready  out  1  drain can accept a tile
- out_data  out  COLS*DATA_W  one row; column c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- busy  out  1  tile held (state != IDLE)
- drain_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, active-high): state=IDLE, row_idx=0, out_valid=0, drain_done=0, busy=0, acc_ready=1. Captured tile contents are don't-care.
- States: IDLE, STREAM.
- IDLE:
  - acc_ready=1.
  - acc_valid && acc_ready: capture acc_in and acc_shift into registers, row_idx<=0, go to STREAM.
  - out_valid rises the next cycle, so capture-to-first-beat latency is 1 cycle.
- STREAM:
  - out_valid=1. out_data = converted row row_idx of the captured tile.
  - out_data stays stable while out_valid && !out_ready.
  - On each fire (out_valid && out_ready): row_idx increments.
- Last beat (row_idx==ROWS-1):
  - A fire on this beat pulses drain_done=1 in the following cycle.
  - If acc_valid is also high in that cycle, the new tile is captured, row_idx<=0, and the state stays STREAM (back-to-back, no bubble).
  - Otherwise the state goes to IDLE.
- acc_ready = IDLE || (STREAM && row_idx==ROWS-1 && out_ready). acc_ready is combinational on out_ready; this is permitted.
- acc_valid while STREAM and not on the last-beat fire: ignored, because acc_ready=0. The producer holds the tile.
- Conversion, per element, with s=shift:
  - Sign-extend x to ACC_W+1 bits.
  - If s>0, add 1<<(s-1).
  - Arithmetic shift right by s.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - s=0 is pure saturation. Conversion is combinational from the capture registers.
- drain_done is exactly one cycle wide; it is never asserted except after the last-beat fire.
- Reset mid-stream: the in-flight tile is discarded; out_valid drops immediately (asynchronously); the next tile starts at row 0.
- busy = (state==STREAM).

Decomposition:
- Package sa_pkg holds:
  - ROWS, COLS, ACC_W, DATA_W, SHIFT_W defaults
  - derived TILE_W=ROWS*COLS*ACC_W and BEAT_W=COLS*DATA_W
  - state enum {IDLE, STREAM}
- One sub-module, sa_round_sat: one element, combinational round/shift/saturate, ACC_W in, DATA_W out. It is instantiated COLS times on the selected row.

Test Plan:
- Ramp, shift 0:
  - Stimulus: element (r,c)=r*8+c; out_ready=1 throughout.
  - Required: 8 consecutive beats; beat r lane c = r*8+c; first beat 1 cycle after capture; drain_done 1 cycle after beat 7.
- Saturation, shift 0:
  - Stimulus: elements 70000, -70000, 32767, -32768.
  - Required lanes: 0x7FFF, 0x8000, 0x7FFF, 0x8000.
- Rounding, shift 4:
  - Stimulus: elements 24, 23, -24, -25, 0x7FFFFFFF.
  - Required outputs: 2, 1, -1, -2, 0x7FFF (saturated).
- Backpressure:
  - Stimulus: out_ready toggled pseudo-randomly, including an 8-cycle stall on beat 3.
  - Required: out_data stable during the stall; beats in order; exactly 8 fires; acc_ready low until the last-beat fire.
- Back-to-back:
  - Stimulus: second tile (all 5) presented with acc_valid held from beat 5.
  - Required: captured on the beat-7 fire; its beat 0 on the next cycle with no bubble; two drain_done pulses.
- Reset mid-stream:
  - Stimulus: assert reset during beat 4.
  - Required: out_valid=0, busy=0, acc_ready=1 immediately; a new tile streams from row 0 with no stale beats.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared defaults and types for the systolic-array result drain.
package sa_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int ACC_W   = 32;
    localparam int DATA_W  = 16;
    localparam int SHIFT_W = 5;

    localparam int TILE_W  = ROWS * COLS * ACC_W;
    localparam int BEAT_W  = COLS * DATA_W;

    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_e;

endpackage

// File: rtl/sa_round_sat.sv
// One accumulator element: round-half-up arithmetic right shift, then
// saturate to a signed DATA_W result. Purely combinational.
module sa_round_sat
    import sa_pkg::*;
#(
    parameter int ACC_W   = sa_pkg::ACC_W,
    parameter int DATA_W  = sa_pkg::DATA_W,
    parameter int SHIFT_W = sa_pkg::SHIFT_W
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [DATA_W-1:0]  data_o
);

    // One extra bit of headroom so the rounding bias never overflows.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // Sign-extend, add half an LSB of the shifted result, shift, clamp.
    always_comb begin
        ext  = {acc_i[ACC_W-1], acc_i};
        bias = '0;
        if (shift_i != '0) begin
            bias = (ACC_W + 1)'(1) << (shift_i - 1'b1);
        end
        rounded = ext + bias;
        shifted = rounded >>> shift_i;
        if (shifted > SAT_MAX) begin
            data_o = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            data_o = OUT_MIN;
        end else begin
            data_o = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/sa_result_drain.sv
// Captures a full accumulator tile in one cycle and streams it out one
// converted row per beat on a valid/ready port, pulsing drain_done once
// the last row has been accepted.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int ROWS    = sa_pkg::ROWS,
    parameter int COLS    = sa_pkg::COLS,
    parameter int ACC_W   = sa_pkg::ACC_W,
    parameter int DATA_W  = sa_pkg::DATA_W,
    parameter int SHIFT_W = sa_pkg::SHIFT_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ROWS*COLS*ACC_W-1:0]   acc_in,
    input  logic [SHIFT_W-1:0]           acc_shift,
    input  logic                         acc_valid,
    output logic                         acc_ready,
    output logic [COLS*DATA_W-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         drain_done
);

    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_BITS = COLS * ACC_W;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    drain_state_e                 state_q, state_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [ROWS*COLS*ACC_W-1:0]   tile_q, tile_d;
    logic [SHIFT_W-1:0]           shift_q, shift_d;
    logic                         done_q, done_d;
    logic                         last_beat;
    logic                         fire;
    logic                         capture;
    logic [ROW_BITS-1:0]          row_sel;

    // Handshakes, next-state and capture decisions.
    always_comb begin
        busy      = (state_q == STREAM);
        out_valid = busy;
        last_beat = (row_q == LAST_ROW);
        fire      = out_valid && out_ready;
        // Accepting during the last-beat fire lets tiles run back-to-back.
        acc_ready = (state_q == IDLE) || (busy && last_beat && out_ready);
        capture   = acc_valid && acc_ready;

        state_d = state_q;
        row_d   = row_q;
        tile_d  = tile_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            STREAM: begin
                if (fire) begin
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture overrides the return to IDLE on the final beat.
        if (capture) begin
            tile_d  = acc_in;
            shift_d = acc_shift;
            row_d   = '0;
            state_d = STREAM;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Tile and shift payload; contents are irrelevant until captured.
    always_ff @(posedge clock) begin
        tile_q  <= tile_d;
        shift_q <= shift_d;
    end

    assign drain_done = done_q;
    assign row_sel    = tile_q[int'(row_q) * ROW_BITS +: ROW_BITS];

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        sa_round_sat #(
            .ACC_W   (ACC_W),
            .DATA_W  (DATA_W),
            .SHIFT_W (SHIFT_W)
        ) u_round_sat (
            .acc_i   (row_sel[c*ACC_W +: ACC_W]),
            .shift_i (shift_q),
            .data_o  (out_data[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: conversion vectors from a table,
// plus hand-written ramp, backpressure, back-to-back and reset sequences.
module tb_sa_result_drain;
    import sa_pkg::*;

    logic                clock;
    logic                reset;
    logic [TILE_W-1:0]   acc_in;
    logic [SHIFT_W-1:0]  acc_shift;
    logic                acc_valid;
    logic                acc_ready;
    logic [BEAT_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                drain_done;

    int errors = 0;
    int checks = 0;

    sa_result_drain #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .ACC_W   (ACC_W),
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .acc_in     (acc_in),
        .acc_shift  (acc_shift),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drain_done (drain_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [ACC_W-1:0]   x;
        logic [SHIFT_W-1:0] s;
        logic [DATA_W-1:0]  want;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [BEAT_W-1:0] act,
                         input logic [BEAT_W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic logic [TILE_W-1:0] fill_tile(input logic [ACC_W-1:0] v);
        logic [TILE_W-1:0] t;
        for (int i = 0; i < ROWS * COLS; i++) t[i*ACC_W +: ACC_W] = v;
        return t;
    endfunction

    function automatic logic [TILE_W-1:0] ramp_tile(input int base, input int mul);
        logic [TILE_W-1:0] t;
        for (int i = 0; i < ROWS * COLS; i++) t[i*ACC_W +: ACC_W] = ACC_W'(base + i * mul);
        return t;
    endfunction

    // Reference conversion in 64-bit integer arithmetic.
    function automatic logic [BEAT_W-1:0] exp_beat(input logic [TILE_W-1:0] t,
                                                   input int s, input int r);
        logic [BEAT_W-1:0]        b;
        logic signed [ACC_W-1:0]  x;
        longint                   v;
        longint                   hi;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        for (int c = 0; c < COLS; c++) begin
            x = t[(r*COLS + c)*ACC_W +: ACC_W];
            v = longint'(x);
            if (s > 0) v = v + (longint'(1) <<< (s - 1));
            v = v >>> s;
            if (v > hi) v = hi;
            if (v < -hi - 1) v = -hi - 1;
            b[c*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
        return b;
    endfunction

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic present_tile(input logic [TILE_W-1:0] t, input logic [SHIFT_W-1:0] s);
        bit ok;
        ok        = 0;
        acc_in    = t;
        acc_shift = s;
        acc_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = acc_ready;
            @(posedge clock);
            #1;
        end
        acc_valid = 1'b0;
        if (!ok) check_bit("capture_timeout", 1'b0, 1'b1);
    endtask

    // Streams a captured tile with out_ready high and checks every beat.
    task automatic drain_all(input logic [TILE_W-1:0] t, input int s, input string tag);
        out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clock);
            check_bit({tag, "_valid"}, out_valid, 1'b1);
            check({tag, $sformatf("_beat%0d", r)}, out_data, exp_beat(t, s, r));
            check_bit({tag, "_done_early"}, drain_done, 1'b0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check_bit({tag, "_done"}, drain_done, 1'b1);
        check_bit({tag, "_valid_end"}, out_valid, 1'b0);
        check_bit({tag, "_busy_end"}, busy, 1'b0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check_bit({tag, "_done_once"}, drain_done, 1'b0);
        @(posedge clock);
        #1;
    endtask

    logic [TILE_W-1:0] t_a, t_b;
    int idx, fires, stall, done_cnt;
    bit got;

    initial begin
        vecs[0]  = '{32'd70000,      5'd0,  16'h7FFF};
        vecs[1]  = '{-32'sd70000,    5'd0,  16'h8000};
        vecs[2]  = '{32'd32767,      5'd0,  16'h7FFF};
        vecs[3]  = '{-32'sd32768,    5'd0,  16'h8000};
        vecs[4]  = '{32'd24,         5'd4,  16'd2};
        vecs[5]  = '{32'd23,         5'd4,  16'd1};
        vecs[6]  = '{-32'sd24,       5'd4,  16'hFFFF};
        vecs[7]  = '{-32'sd25,       5'd4,  16'hFFFE};
        vecs[8]  = '{32'h7FFFFFFF,   5'd4,  16'h7FFF};
        vecs[9]  = '{-32'sd8,        5'd4,  16'd0};
        vecs[10] = '{-32'sd9,        5'd4,  16'hFFFF};
        vecs[11] = '{32'd7,          5'd1,  16'd4};
        vecs[12] = '{-32'sd1,        5'd31, 16'd0};
        vecs[13] = '{32'h80000000,   5'd31, 16'hFFFF};
        vecs[14] = '{32'h7FFFFFFF,   5'd31, 16'd1};
        vecs[15] = '{32'd65535,      5'd2,  16'h4000};
        vecs[16] = '{32'd65533,      5'd1,  16'h7FFF};
        vecs[17] = '{32'd65535,      5'd1,  16'h7FFF};
        vecs[18] = '{-32'sd65539,    5'd1,  16'h8000};

        reset     = 1'b1;
        acc_in    = '0;
        acc_shift = '0;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_acc_ready", acc_ready, 1'b1);
        check_bit("rst_done", drain_done, 1'b0);
        @(posedge clock);
        #1;

        // Ramp, shift 0: lane c of beat r carries r*8+c
        t_a = ramp_tile(0, 1);
        out_ready = 1'b1;
        present_tile(t_a, 5'd0);
        drain_all(t_a, 0, "ramp");

        // Conversion table: every element of the tile carries the vector value
        for (int i = 0; i < NVEC; i++) begin
            out_ready = 1'b1;
            present_tile(fill_tile(vecs[i].x), vecs[i].s);
            @(negedge clock);
            check($sformatf("vec%0d", i), out_data, {COLS{vecs[i].want}});
            @(posedge clock);
            #1;
            got = 0;
            for (int k = 0; k < ROWS + 4 && !got; k++) begin
                @(negedge clock);
                got = drain_done;
                @(posedge clock);
                #1;
            end
            check_bit($sformatf("vec%0d_done", i), got, 1'b1);
        end

        // Backpressure with an 8-cycle stall on beat 3
        t_a = ramp_tile(-1000, 37);
        out_ready = 1'b0;
        present_tile(t_a, 5'd3);
        idx = 0;
        fires = 0;
        stall = 0;
        for (int cyc = 0; cyc < 300 && idx < ROWS; cyc++) begin
            if (idx == 3 && stall < 8) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(0, 1) == 1);
            end
            @(negedge clock);
            check_bit("bp_valid", out_valid, 1'b1);
            check($sformatf("bp_beat%0d", idx), out_data, exp_beat(t_a, 3, idx));
            check_bit("bp_acc_ready", acc_ready, (idx == ROWS - 1) && out_ready);
            check_bit("bp_done_early", drain_done, 1'b0);
            if (out_ready) begin
                idx++;
                fires++;
            end
            @(posedge clock);
            #1;
        end
        check_int("bp_fires", fires, ROWS);
        check_int("bp_stall_len", stall, 8);
        out_ready = 1'b1;
        @(negedge clock);
        check_bit("bp_done", drain_done, 1'b1);
        check_bit("bp_valid_end", out_valid, 1'b0);
        @(posedge clock);
        #1;

        // Back-to-back: second tile held valid from beat 5 of the first
        t_a = ramp_tile(0, 1);
        t_b = fill_tile(32'd5);
        out_ready = 1'b1;
        present_tile(t_a, 5'd0);
        done_cnt = 0;
        for (idx = 0; idx < 2 * ROWS; idx++) begin
            if (idx >= 5 && idx < ROWS) begin
                acc_in    = t_b;
                acc_shift = 5'd0;
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            @(negedge clock);
            check_bit("b2b_valid", out_valid, 1'b1);
            check($sformatf("b2b_beat%0d", idx),
                  out_data, exp_beat(idx < ROWS ? t_a : t_b, 0, idx % ROWS));
            if (idx >= 5 && idx < ROWS)
                check_bit($sformatf("b2b_acc_ready%0d", idx), acc_ready, idx == ROWS - 1);
            if (idx == ROWS) check_bit("b2b_done_first", drain_done, 1'b1);
            if (drain_done) done_cnt++;
            @(posedge clock);
            #1;
        end
        acc_valid = 1'b0;
        @(negedge clock);
        if (drain_done) done_cnt++;
        check_int("b2b_done_pulses", done_cnt, 2);
        check_bit("b2b_valid_end", out_valid, 1'b0);
        @(posedge clock);
        #1;

        // Reset during beat 4, then a fresh tile from row 0
        t_a = ramp_tile(0, 1);
        out_ready = 1'b1;
        present_tile(t_a, 5'd0);
        for (int r = 0; r < 5; r++) begin
            @(negedge clock);
            check($sformatf("rst_mid_beat%0d", r), out_data, exp_beat(t_a, 0, r));
            if (r < 4) begin
                @(posedge clock);
                #1;
            end
        end
        #1;
        reset = 1'b1;
        #1;
        check_bit("rst_mid_valid", out_valid, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_acc_ready", acc_ready, 1'b1);
        check_bit("rst_mid_done", drain_done, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        t_b = ramp_tile(100, 3);
        present_tile(t_b, 5'd2);
        drain_all(t_b, 2, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
